// File: rtl/k005297_dmadbuf_if.sv
// k005297_dmadbuf_if: bubble serial and DMA word signals of the buffered data path
interface k005297_dmadbuf_if #(
    parameter int W  = 16,
    parameter int LW = 3
);
    logic          i_CLK4M_PCEN_n;
    logic          i_EN;
    logic          i_DIR;
    logic          i_FLUSH;
    logic          i_BIT_STB;
    logic          i_BDI;
    logic          o_BDO;
    logic [W-1:0]  i_DMA_DIN;
    logic          i_DMA_WR;
    logic          o_DMA_READY;
    logic [W-1:0]  o_DMA_DOUT;
    logic          o_DMA_VALID;
    logic          i_DMA_ACK;
    logic          o_ADDR_INC;
    logic [LW-1:0] o_LEVEL;
    logic          o_OVR;
    logic          o_UDR;

    modport master (
        output i_CLK4M_PCEN_n, i_EN, i_DIR, i_FLUSH, i_BIT_STB, i_BDI, i_DMA_DIN, i_DMA_WR, i_DMA_ACK,
        input  o_BDO, o_DMA_READY, o_DMA_DOUT, o_DMA_VALID, o_ADDR_INC, o_LEVEL, o_OVR, o_UDR
    );
    modport slave (
        input  i_CLK4M_PCEN_n, i_EN, i_DIR, i_FLUSH, i_BIT_STB, i_BDI, i_DMA_DIN, i_DMA_WR, i_DMA_ACK,
        output o_BDO, o_DMA_READY, o_DMA_DOUT, o_DMA_VALID, o_ADDR_INC, o_LEVEL, o_OVR, o_UDR
    );
endinterface

// File: rtl/k005297_dmadbuf.sv
// k005297_dmadbuf: bubble bit stream <-> DMA words through a DEPTH-word FIFO
module k005297_dmadbuf #(
    parameter int WORD_BYTES = 2,
    parameter int DEPTH      = 4
) (
    input logic              i_MCLK,
    input logic              i_RST,
    k005297_dmadbuf_if.slave bus
);
    localparam int W  = 8 * WORD_BYTES;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] LAST  = IW'(W - 1);
    localparam logic [LW-1:0] FULLC = LW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  wreg_q, wreg_d, head, word_in;
    logic [IW-1:0] idx_q, idx_d;
    logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic          wv_q, wv_d, dir_q, inc_q, inc_d, ovr_q, ovr_d, udr_q, udr_d;
    logic          tick, flush, full, empty, last;
    logic          rd_pop, rd_bit, rd_done, push_r, w_act, w_load, w_bit, w_end, w_pop, push_w, push, pop;

    assign head = mem_q[rp_q];

    // Next state: read mode shifts bits in and pushes words; write mode pops words and shifts bits out
    always_comb begin
        tick    = !bus.i_CLK4M_PCEN_n;
        flush   = tick & (bus.i_FLUSH | (bus.i_EN & (bus.i_DIR != dir_q)));
        full    = cnt_q == FULLC;
        empty   = cnt_q == '0;
        last    = idx_q == LAST;
        word_in = {wreg_q[W-2:0], bus.i_BDI};
        rd_pop  = !dir_q & bus.i_DMA_ACK & !empty;
        rd_bit  = !dir_q & bus.i_EN & bus.i_BIT_STB;
        rd_done = rd_bit & last;
        push_r  = rd_done & (!full | rd_pop);
        w_act   = dir_q & bus.i_EN;
        w_load  = w_act & !wv_q & !empty;
        w_bit   = w_act & wv_q & bus.i_BIT_STB;
        w_end   = w_bit & last;
        w_pop   = w_load | (w_end & !empty);
        push_w  = dir_q & bus.i_DMA_WR & (!full | w_pop);
        push    = push_r | push_w;
        pop     = rd_pop | w_pop;
        wreg_d  = w_pop ? head : rd_bit ? word_in : w_bit ? {wreg_q[W-2:0], 1'b0} : wreg_q;
        idx_d   = w_load ? '0 : (rd_bit | w_bit) ? (last ? '0 : idx_q + 1'b1) : idx_q;
        wv_d    = w_load | (wv_q & !(w_end & empty));
        cnt_d   = cnt_q + LW'(push) - LW'(pop);
        rp_d    = rp_q + AW'(pop);
        wp_d    = wp_q + AW'(push);
        inc_d   = rd_pop | push_w;
        ovr_d   = ovr_q | (rd_done & full & !rd_pop);
        udr_d   = udr_q | (w_act & bus.i_BIT_STB & (!wv_q | (last & empty)));
    end

    // State update on ticks; flush clears everything but still samples the direction
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            wreg_q <= '0;
            idx_q  <= '0;
            rp_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            wv_q   <= 1'b0;
            dir_q  <= 1'b0;
            inc_q  <= 1'b0;
            ovr_q  <= 1'b0;
            udr_q  <= 1'b0;
        end else if (flush) begin
            wreg_q <= '0;
            idx_q  <= '0;
            rp_q   <= '0;
            wp_q   <= '0;
            cnt_q  <= '0;
            wv_q   <= 1'b0;
            dir_q  <= bus.i_DIR;
            inc_q  <= 1'b0;
            ovr_q  <= 1'b0;
            udr_q  <= 1'b0;
        end else if (tick) begin
            wreg_q <= wreg_d;
            idx_q  <= idx_d;
            rp_q   <= rp_d;
            wp_q   <= wp_d;
            cnt_q  <= cnt_d;
            wv_q   <= wv_d;
            dir_q  <= bus.i_DIR;
            inc_q  <= inc_d;
            ovr_q  <= ovr_d;
            udr_q  <= udr_d;
        end
    end

    // FIFO storage; contents need no reset since the head is masked while empty
    always_ff @(posedge i_MCLK) begin
        if (tick & !flush & push) mem_q[wp_q] <= push_w ? bus.i_DMA_DIN : word_in;
    end

    assign bus.o_DMA_VALID = !dir_q & !empty;
    assign bus.o_DMA_READY = dir_q & !full;
    assign bus.o_DMA_DOUT  = bus.o_DMA_VALID ? head : '0;
    assign bus.o_BDO       = wreg_q[W-1] & wv_q;
    assign bus.o_ADDR_INC  = inc_q;
    assign bus.o_LEVEL     = cnt_q;
    assign bus.o_OVR       = ovr_q;
    assign bus.o_UDR       = udr_q;
endmodule

// File: tb/tb_k005297_dmadbuf.sv
// tb_k005297_dmadbuf: queue-based reference model with per-cycle output comparison
module tb_k005297_dmadbuf;
    localparam int W     = 16;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    k005297_dmadbuf_if #(.W(W), .LW(3)) bus();
    k005297_dmadbuf #(.WORD_BYTES(2), .DEPTH(DEPTH)) dut (.i_MCLK(clk), .i_RST(rst), .bus(bus));

    int errors = 0;
    int checks = 0;

    logic [W-1:0] q[$];
    logic         m_dir, m_wv, m_ovr, m_udr, m_inc;
    int           m_n, m_pos;
    logic [W-1:0] m_acc, m_word;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        q.delete();
        m_acc = '0; m_n = 0; m_word = '0; m_pos = 0;
        m_wv = 0; m_ovr = 0; m_udr = 0; m_inc = 0;
    endtask

    task automatic m_step();
        bit spop, push, pop;
        if (bus.i_CLK4M_PCEN_n) return;
        if (bus.i_FLUSH || (bus.i_EN && bus.i_DIR != m_dir)) begin
            m_clear();
            m_dir = bus.i_DIR;
            return;
        end
        spop = 0;
        if (!m_dir) begin
            pop = bus.i_DMA_ACK && q.size() > 0;
            if (pop) void'(q.pop_front());
            if (bus.i_EN && bus.i_BIT_STB) begin
                m_acc = W'(m_acc * 2 + bus.i_BDI);
                m_n++;
                if (m_n == W) begin
                    m_n = 0;
                    if (q.size() < DEPTH) q.push_back(m_acc);
                    else m_ovr = 1;
                end
            end
            m_inc = pop;
        end else begin
            if (bus.i_EN) begin
                if (!m_wv) begin
                    if (bus.i_BIT_STB) m_udr = 1;
                    spop = q.size() > 0;
                end else if (bus.i_BIT_STB) begin
                    if (m_pos == W - 1) begin
                        if (q.size() > 0) spop = 1;
                        else begin m_wv = 0; m_udr = 1; end
                    end else m_pos++;
                end
            end
            push = bus.i_DMA_WR && (q.size() < DEPTH || spop);
            if (spop) begin m_word = q.pop_front(); m_wv = 1; m_pos = 0; end
            if (push) q.push_back(bus.i_DMA_DIN);
            m_inc = push;
        end
        m_dir = bus.i_DIR;
    endtask

    task automatic check_all();
        logic         v;
        logic [W-1:0] d;
        v = !m_dir && q.size() > 0;
        d = v ? q[0] : '0;
        chk("valid", bus.o_DMA_VALID, v);
        chk("ready", bus.o_DMA_READY, m_dir && q.size() < DEPTH);
        chk("dout", bus.o_DMA_DOUT, d);
        chk("bdo", bus.o_BDO, m_wv ? m_word[W-1-m_pos] : 1'b0);
        chk("addr_inc", bus.o_ADDR_INC, m_inc);
        chk("level", bus.o_LEVEL, q.size());
        chk("ovr", bus.o_OVR, m_ovr);
        chk("udr", bus.o_UDR, m_udr);
    endtask

    task automatic step();
        m_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic shift_word(input logic [W-1:0] w);
        for (int k = 0; k < W; k++) begin
            bus.i_BIT_STB = 1'b1;
            bus.i_BDI = w[W-1-k];
            step();
        end
        bus.i_BIT_STB = 1'b0;
    endtask

    initial begin
        logic [W-1:0] words [5];
        logic [31:0]  wpat;
        int           pulses;
        bus.i_CLK4M_PCEN_n = 1'b0; bus.i_EN = 1'b0; bus.i_DIR = 1'b0; bus.i_FLUSH = 1'b0;
        bus.i_BIT_STB = 1'b0; bus.i_BDI = 1'b0; bus.i_DMA_DIN = '0; bus.i_DMA_WR = 1'b0; bus.i_DMA_ACK = 1'b0;
        m_dir = 0;
        m_clear();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;
        bus.i_EN = 1'b1;

        shift_word(16'hA5C3);
        chk("rd_valid", bus.o_DMA_VALID, 1);
        chk("rd_dout", bus.o_DMA_DOUT, 16'hA5C3);
        chk("rd_level", bus.o_LEVEL, 1);
        bus.i_DMA_ACK = 1'b1; step(); bus.i_DMA_ACK = 1'b0;
        chk("rd_ack_inc", bus.o_ADDR_INC, 1);
        step();
        chk("rd_inc_one_tick", bus.o_ADDR_INC, 0);

        for (int i = 0; i < 5; i++) begin
            words[i] = W'($urandom);
            shift_word(words[i]);
        end
        chk("ovr_level", bus.o_LEVEL, 4);
        chk("ovr_flag", bus.o_OVR, 1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            chk("ovr_order", bus.o_DMA_DOUT, words[i]);
            bus.i_DMA_ACK = 1'b1; step(); bus.i_DMA_ACK = 1'b0;
            if (bus.o_ADDR_INC) pulses++;
            step();
        end
        chk("ovr_pulses", pulses, 4);
        bus.i_DMA_ACK = 1'b1; step(); bus.i_DMA_ACK = 1'b0;
        chk("ack_empty_ignored", bus.o_ADDR_INC, 0);
        bus.i_FLUSH = 1'b1; step(); bus.i_FLUSH = 1'b0;
        chk("flush_ovr", bus.o_OVR, 0);

        for (int k = 0; k < 7; k++) begin
            bus.i_BIT_STB = 1'b1; bus.i_BDI = 1'($urandom); step();
        end
        bus.i_BIT_STB = 1'b0;
        bus.i_FLUSH = 1'b1; step(); bus.i_FLUSH = 1'b0;
        shift_word(16'h3C96);
        chk("flush_midword_dout", bus.o_DMA_DOUT, 16'h3C96);
        bus.i_DMA_ACK = 1'b1; step(); bus.i_DMA_ACK = 1'b0;

        bus.i_DIR = 1'b1; step();
        bus.i_DMA_WR = 1'b1; bus.i_DMA_DIN = 16'h8001; step();
        bus.i_DMA_DIN = 16'hFFFF; step();
        bus.i_DMA_WR = 1'b0;
        wpat = 32'h8001FFFF;
        for (int k = 0; k < 32; k++) begin
            chk("wr_bdo", bus.o_BDO, wpat[31-k]);
            bus.i_BIT_STB = 1'b1; step();
        end
        chk("wr_udr_end", bus.o_UDR, 1);
        step();
        chk("wr_udr", bus.o_UDR, 1);
        chk("wr_udr_bdo", bus.o_BDO, 0);
        bus.i_BIT_STB = 1'b0;

        bus.i_FLUSH = 1'b1; step(); bus.i_FLUSH = 1'b0;
        chk("flush_udr", bus.o_UDR, 0);
        bus.i_EN = 1'b0; bus.i_DMA_WR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.i_DMA_DIN = W'($urandom); step();
        end
        chk("full_level", bus.o_LEVEL, 4);
        chk("full_ready", bus.o_DMA_READY, 0);
        bus.i_EN = 1'b1; bus.i_DMA_DIN = 16'h1234; step();
        bus.i_DMA_WR = 1'b0;
        chk("simul_level", bus.o_LEVEL, 4);
        chk("simul_inc", bus.o_ADDR_INC, 1);

        bus.i_BIT_STB = 1'b1;
        repeat (7) step();
        bus.i_BIT_STB = 1'b0;
        bus.i_DIR = 1'b0; step();
        chk("flip_level", bus.o_LEVEL, 0);
        chk("flip_bdo", bus.o_BDO, 0);
        chk("flip_udr", bus.o_UDR, 0);

        bus.i_DIR = 1'b1; step();
        bus.i_DMA_WR = 1'b1;
        repeat (2) begin bus.i_DMA_DIN = W'($urandom); step(); end
        bus.i_DMA_WR = 1'b0; bus.i_BIT_STB = 1'b1;
        repeat (5) step();
        bus.i_BIT_STB = 1'b0;
        bus.i_CLK4M_PCEN_n = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("arst_level", bus.o_LEVEL, 0);
        chk("arst_bdo", bus.o_BDO, 0);
        chk("arst_ready", bus.o_DMA_READY, 0);
        chk("arst_valid", bus.o_DMA_VALID, 0);
        chk("arst_dout", bus.o_DMA_DOUT, 0);
        chk("arst_inc", bus.o_ADDR_INC, 0);
        chk("arst_flags", {bus.o_OVR, bus.o_UDR}, 0);
        m_dir = 0;
        m_clear();
        @(negedge clk);
        rst = 1'b0;
        bus.i_DIR = 1'b0;
        bus.i_CLK4M_PCEN_n = 1'b0;
        check_all();

        for (int seg = 0; seg < 12; seg++) begin
            int ack_rate, wr_rate;
            ack_rate = $urandom_range(0, 8);
            wr_rate = $urandom_range(0, 8);
            bus.i_DIR = seg[0]; bus.i_EN = 1'b1; bus.i_CLK4M_PCEN_n = 1'b0; bus.i_FLUSH = 1'b0;
            step();
            for (int c = 0; c < 300; c++) begin
                bus.i_CLK4M_PCEN_n = ($urandom % 4 == 0);
                bus.i_EN = ($urandom % 8 != 0);
                bus.i_FLUSH = ($urandom % 128 == 0);
                bus.i_BIT_STB = 1'($urandom);
                bus.i_BDI = 1'($urandom);
                bus.i_DMA_DIN = W'($urandom);
                bus.i_DMA_WR = ($urandom_range(0, 7) < wr_rate);
                bus.i_DMA_ACK = ($urandom_range(0, 7) < ack_rate);
                if ($urandom % 200 == 0) begin
                    bus.i_DIR = ~bus.i_DIR; bus.i_EN = 1'b1; bus.i_CLK4M_PCEN_n = 1'b0;
                end
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
